// File: rtl/ex3_to_bcd_deser.sv
// Excess-3 to BCD deserializer: decodes one Excess-3 nibble per accept and packs
// up to NDIGITS digits (MSD first) into a parallel BCD word on a valid/ready output.
module ex3_to_bcd_deser #(
    parameter  int NDIGITS = 4,
    localparam int CW      = $clog2(NDIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_ex3,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] out_bcd,
    output logic [CW-1:0]        out_count,
    output logic                 out_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic                 accept;
    logic                 code_ok;
    logic                 closing;
    logic [3:0]           digit;
    logic [4*NDIGITS-1:0] bcd_shift;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // Codes outside 3..12 have no BCD meaning; they become digit 0 and flag the frame.
    assign code_ok = (in_ex3 >= 4'd3) && (in_ex3 <= 4'd12);
    assign digit   = code_ok ? (in_ex3 - 4'd3) : 4'd0;
    assign closing = in_last || (out_count == CW'(NDIGITS - 1));

    generate
        if (NDIGITS == 1) begin : g_single
            assign bcd_shift = digit;
        end else begin : g_multi
            assign bcd_shift = {out_bcd[4*NDIGITS-5:0], digit};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && closing) state_next = HOLD;
            HOLD:    if (out_ready)         state_next = COLLECT;
            default:                        state_next = COLLECT;
        endcase
    end

    // The output handshake clears the frame, so the next frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_bcd   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_bcd   <= bcd_shift;
            out_count <= out_count + CW'(1);
            if (!code_ok) begin
                out_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex3_to_bcd_deser.sv
// Directed self-checking bench for ex3_to_bcd_deser (NDIGITS=4) with immediate
// assertions; expected values are hand-computed Excess-3 minus 3 decodes.
module tb_ex3_to_bcd_deser;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ex3;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [2:0]  out_count;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    ex3_to_bcd_deser #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ex3    (in_ex3),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends n digits back-to-back; codes holds the first digit in [15:12].
    task automatic applyStimulus(input logic [15:0] codes, input int n, input bit lastOnFinal);
        logic [15:0] c;
        c = codes;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_ex3   = c[15-4*i -: 4];
            in_last  = lastOnFinal && (i == n - 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_ex3   = 4'h0;
    endtask

    task automatic checkFrame(input string tag, input logic [15:0] expBcd, input logic [2:0] expCount, input logic expErr);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_bcd"},   32'(out_bcd), 32'(expBcd));
        checkOutput({tag, "_count"}, 32'(out_count), 32'(expCount));
        checkOutput({tag, "_err"},   32'(out_err), 32'(expErr));
    endtask

    task automatic popFrame(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_pop_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_pop_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_pop_count"}, 32'(out_count), 32'd0);
        checkOutput({tag, "_pop_bcd"},   32'(out_bcd), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_ex3    = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_bcd",   32'(out_bcd), 32'd0);
        checkOutput("rst_count", 32'(out_count), 32'd0);
        checkOutput("rst_err",   32'(out_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with out_ready held high throughout: it has no effect in COLLECT.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ex3 = 4'h4; @(posedge clk); #1;
        in_ex3 = 4'h5; @(posedge clk); #1;
        checkOutput("t1_partial_count", 32'(out_count), 32'd2);
        checkOutput("t1_partial_valid", 32'(out_valid), 32'd0);
        in_ex3 = 4'h6; @(posedge clk); #1;
        in_ex3 = 4'h7; @(posedge clk); #1;
        in_valid = 1'b0;
        checkFrame("t1", 16'h1234, 3'd4, 1'b0);
        @(posedge clk); #1;
        checkOutput("t1_drop_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_drop_ready", 32'(in_ready), 32'd1);
        checkOutput("t1_drop_count", 32'(out_count), 32'd0);
        out_ready = 1'b0;

        // Full valid code sweep 0x3..0xC.
        applyStimulus(16'h3456, 4, 1'b0);
        checkFrame("t2a", 16'h0123, 3'd4, 1'b0);
        popFrame("t2a");
        applyStimulus(16'h789A, 4, 1'b0);
        checkFrame("t2b", 16'h4567, 3'd4, 1'b0);
        popFrame("t2b");
        applyStimulus(16'h9ABC, 4, 1'b1);
        checkFrame("t2c", 16'h6789, 3'd4, 1'b0);
        popFrame("t2c");

        // Invalid codes decode to 0 and set the sticky error; next frame is clean.
        applyStimulus(16'h4F0C, 4, 1'b0);
        checkFrame("t3a", 16'h1009, 3'd4, 1'b1);
        popFrame("t3a");
        checkOutput("t3a_pop_err", 32'(out_err), 32'd0);
        applyStimulus(16'h3333, 4, 1'b0);
        checkFrame("t3b", 16'h0000, 3'd4, 1'b0);
        popFrame("t3b");
        applyStimulus(16'h1000, 1, 1'b1);
        checkFrame("t3c", 16'h0000, 3'd1, 1'b1);
        popFrame("t3c");

        // Early termination keeps the value right-aligned.
        applyStimulus(16'h8B00, 2, 1'b1);
        checkFrame("t4a", 16'h0058, 3'd2, 1'b0);
        popFrame("t4a");
        applyStimulus(16'h3000, 1, 1'b1);
        checkFrame("t4b", 16'h0000, 3'd1, 1'b0);
        popFrame("t4b");
        applyStimulus(16'hC500, 2, 1'b0);
        checkOutput("t4c_open_valid", 32'(out_valid), 32'd0);
        checkOutput("t4c_open_bcd",   32'(out_bcd), 32'h0092);
        applyStimulus(16'h4800, 1, 1'b1);
        checkFrame("t4c", 16'h0921, 3'd3, 1'b0);
        popFrame("t4c");

        // Backpressure: in_valid held with 0x9 while the frame waits.
        applyStimulus(16'h4560, 3, 1'b0);
        in_valid = 1'b1;
        in_ex3   = 4'h7;
        @(posedge clk); #1;
        in_ex3 = 4'h9;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5_stall_valid", 32'(out_valid), 32'd1);
            checkOutput("t5_stall_ready", 32'(in_ready), 32'd0);
            checkOutput("t5_stall_bcd",   32'(out_bcd), 32'h1234);
            checkOutput("t5_stall_count", 32'(out_count), 32'd4);
            @(posedge clk); #1;
        end
        checkOutput("t5_stall_end_bcd", 32'(out_bcd), 32'h1234);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("t5_hs_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_hs_ready", 32'(in_ready), 32'd1);
        checkOutput("t5_hs_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("t5_next_count", 32'(out_count), 32'd1);
        checkOutput("t5_next_bcd",   32'(out_bcd), 32'h0006);
        applyStimulus(16'h9990, 3, 1'b1);
        checkFrame("t5", 16'h6666, 3'd4, 1'b0);
        popFrame("t5");

        // Asynchronous reset between clock edges discards a partial frame.
        applyStimulus(16'h4500, 2, 1'b0);
        checkOutput("t6_pre_bcd",   32'(out_bcd), 32'h0012);
        checkOutput("t6_pre_count", 32'(out_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_bcd",   32'(out_bcd), 32'd0);
        checkOutput("t6_rst_count", 32'(out_count), 32'd0);
        checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_ready", 32'(in_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'h7777, 4, 1'b0);
        checkFrame("t6", 16'h4444, 3'd4, 1'b0);
        popFrame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex3_to_bcd_deser.md
Name: ex3_to_bcd_deser

Overview:
Receive-side counterpart of the BCD-to-Excess-3 encoder. Accepts a stream of Excess-3 coded nibbles, one per accepted handshake, and validates and decodes each one to BCD (code minus 3). Packs up to NDIGITS decoded digits, most significant digit first, into a parallel BCD word. Presents the word on a valid/ready output handshake, together with the digit count and a sticky code-error flag.

Parameters:
NDIGITS, 4, maximum digits per frame (>=1); out_bcd width is 4*NDIGITS.
CW, $clog2(NDIGITS+1), derived width of out_count (localparam, not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_ex3/in_last are valid.
in_ready  output  1  block can accept a digit.
in_ex3  input  4  Excess-3 coded digit.
in_last  input  1  marks the final digit of a frame; sampled only on accept.
out_valid  output  1  frame complete; out_bcd/out_count/out_err valid.
out_ready  input  1  downstream accepts the frame.
out_bcd  output  4*NDIGITS  packed BCD. Digit 0 is in bits [3:0]. Right-aligned, zero-padded above.
out_count  output  CW  digits in frame, 1..NDIGITS.
out_err  output  1  at least one invalid code in the frame.

Behaviour:
- Reset (rst_n=0, asynchronous): state=COLLECT, out_bcd=0, out_count=0, out_err=0, out_valid=0, in_ready=1 once reset is released. Reset mid-frame discards the partial frame.
- FSM, two states:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready.
- On accept:
  - Valid code (in_ex3 in 3..12): decode as in_ex3 - 3, computed 4-bit.
  - Invalid code (0,1,2,13,14,15): store digit 0 and set out_err (sticky for the frame).
  - out_bcd <= {out_bcd[4*NDIGITS-5:0], digit}, i.e. left shift by one nibble.
  - out_count increments.
- Transition COLLECT->HOLD on an accept where in_last=1 OR the accept brings out_count to NDIGITS.
  - in_last is irrelevant on the NDIGITS-th digit; the frame closes regardless.
- Latency: out_valid rises on the clock edge that accepts the closing digit, so it is visible in the following cycle.
- HOLD: out_bcd, out_count and out_err are held stable. in_valid is ignored and no data is consumed.
- HOLD->COLLECT on out_valid && out_ready. The same edge clears out_bcd, out_count and out_err to 0.
  - No input accept occurs in that cycle (in_ready=0), so the first digit of the next frame is accepted one cycle after the output handshake at the earliest.
- out_ready while in COLLECT has no effect.
- Early-closed frame (in_last before NDIGITS): the upper nibbles remain 0, so the numeric value is preserved.
- During COLLECT, out_bcd/out_count show partial contents; downstream must qualify them with out_valid.
- No combinational path from inputs to outputs; all outputs are registered or decoded directly from state.

Test Plan:
1. NDIGITS=4. Send in_ex3 0x4,0x5,0x6,0x7 back-to-back, in_last=0 -> out_valid the cycle after the 4th accept; out_bcd=0x1234, out_count=4, out_err=0. Hold out_ready=1 -> out_valid drops next cycle and in_ready returns to 1.
2. Full code sweep: send frames covering in_ex3 0x3..0xC -> decoded digits 0..9 in order. For example, frame 0x3,0x4,0x5,0x6 gives 0x0123, and frame 0x9,0xA,0xB,0xC gives 0x6789. out_err=0 throughout.
3. Invalid codes: send 0x4,0xF,0x0,0xC -> out_bcd=0x1009, out_err=1, out_count=4. The next frame 0x3,0x3,0x3,0x3 -> out_err=0, confirming the flag clears per frame.
4. Early termination: send 0x8, then 0xB with in_last=1 -> out_bcd=0x0058, out_count=2. in_last=1 on the 1st digit 0x3 -> out_bcd=0x0000, out_count=1.
5. Backpressure: complete frame 0x4,0x5,0x6,0x7 with out_ready=0 for 5 cycles while in_valid=1 and in_ex3=0x9 are held.
   - During the stall: in_ready=0, out_bcd stays 0x1234, and no digit is consumed.
   - After out_ready=1: the handshake completes, then 0x9 is accepted as digit 6 of the next frame one cycle later.
6. Asynchronous reset mid-frame: after accepting 0x4,0x5, pulse rst_n low between clock edges.
   - Outputs clear immediately (out_bcd=0, out_count=0, out_valid=0).
   - Next frame 0x7,0x7,0x7,0x7 -> out_bcd=0x4444, out_err=0.
